hazard_ctrl: RTL and testbench

//  Back-pressure/steering unit for the 5-stage pipeline. It reads dest/source/control fields from the IF/DE, ID/EX, EX/MEM and MEM/WB registers.
//  It drives enable/flush back into those registers and the PC, plus EX-stage forwarding selects.
//  FSM covers load-use stall, taken-branch flush and multi-cycle data-memory wait. Saturating perf counters; sticky timeout flag.

---
 rtl/hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use stall, taken-branch flush, data-memory wait freeze, EX-stage forwarding.
// Latency: enables/flushes/forward selects are combinational from inputs and state; counters/flag update on the next edge.
// Backpressure: a pending data-memory access freezes PC..EX/MEM and bubbles MEM/WB until dmem_ready_i returns.
module hazard_ctrl #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rn_i,
    input  logic [4:0]       id_rm_i,
    input  logic             id_use_rn_i,
    input  logic             id_use_rm_i,
    input  logic [4:0]       ex_rn_i,
    input  logic [4:0]       ex_rm_i,
    input  logic [4:0]       ex_destreg_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       mem_destreg_i,
    input  logic             mem_regwrite_i,
    input  logic [4:0]       wb_destreg_i,
    input  logic             wb_regwrite_i,
    input  logic             br_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_en_o,
    output logic             ifde_en_o,
    output logic             idex_en_o,
    output logic             exmem_en_o,
    output logic             ifde_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             memwb_bubble_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             mem_timeout_o
);

    localparam logic [4:0] XZR  = 5'd31;
    localparam int         WC_W = $clog2(WAIT_MAX + 1);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(WAIT_MAX);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    logic             mem_stall;
    logic             load_use;
    logic             stall_inc;
    logic             flush_inc;

    // EX/MEM result is newer than MEM/WB, so it wins when both match; XZR is never a real dependency.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] mem_dst,
        input logic       mem_wr,
        input logic [4:0] wb_dst,
        input logic       wb_wr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != XZR) begin
            if (mem_wr && (mem_dst == src)) begin
                sel = 2'b10;
            end else if (wb_wr && (wb_dst == src)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    assign mem_stall = dmem_req_i & ~dmem_ready_i;
    assign load_use  = ex_memread_i & (ex_destreg_i != XZR) &
                       ((id_use_rn_i & (id_rn_i == ex_destreg_i)) |
                        (id_use_rm_i & (id_rm_i == ex_destreg_i)));

    // Next state and pipeline controls; priority is memory freeze, then branch flush, then load-use.
    always_comb begin
        state_d        = RUN;
        pc_en_o        = 1'b1;
        ifde_en_o      = 1'b1;
        idex_en_o      = 1'b1;
        exmem_en_o     = 1'b1;
        ifde_flush_o   = 1'b0;
        idex_flush_o   = 1'b0;
        exmem_flush_o  = 1'b0;
        memwb_bubble_o = 1'b0;
        fwd_a_o        = fwd_sel(ex_rn_i, mem_destreg_i, mem_regwrite_i, wb_destreg_i, wb_regwrite_i);
        fwd_b_o        = fwd_sel(ex_rm_i, mem_destreg_i, mem_regwrite_i, wb_destreg_i, wb_regwrite_i);
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;

        if (mem_stall) begin
            state_d        = MEM_WAIT;
            pc_en_o        = 1'b0;
            ifde_en_o      = 1'b0;
            idex_en_o      = 1'b0;
            exmem_en_o     = 1'b0;
            memwb_bubble_o = 1'b1;
            stall_inc      = 1'b1;
        end else if (br_taken_i) begin
            // Wrong-path instructions are squashed; any pending load-use stall is moot.
            ifde_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
            flush_inc     = 1'b1;
        end else if ((state_q == RUN) && load_use) begin
            // Hold the consumer in IF/DE for one cycle and let a NOP enter EX behind the load.
            state_d      = LU_STALL;
            pc_en_o      = 1'b0;
            ifde_en_o    = 1'b0;
            idex_flush_o = 1'b1;
            stall_inc    = 1'b1;
        end

        if (reset) begin
            pc_en_o        = 1'b1;
            ifde_en_o      = 1'b1;
            idex_en_o      = 1'b1;
            exmem_en_o     = 1'b1;
            ifde_flush_o   = 1'b0;
            idex_flush_o   = 1'b0;
            exmem_flush_o  = 1'b0;
            memwb_bubble_o = 1'b0;
            fwd_a_o        = 2'b00;
            fwd_b_o        = 2'b00;
        end
    end

    // Saturating perf counters, consecutive-wait counter and sticky timeout flag.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = '0;
        timeout_d   = timeout_q;
        if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (mem_stall) begin
            wait_cnt_d = (wait_cnt_q == WC_MAX) ? wait_cnt_q : wait_cnt_q + WC_W'(1);
            if (wait_cnt_q >= WC_LAST) begin
                timeout_d = 1'b1;
            end
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
    assign mem_timeout_o = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of per-cycle vectors plus a hand-written memory-wait sequence.
// Counters are narrowed so saturation is reachable; WAIT_MAX is small so the timeout can be provoked.
// Inputs change on the falling edge; outputs are compared shortly after, well before the rising edge.
module tb_hazard_ctrl;

    localparam int CNT_W    = 3;
    localparam int WAIT_MAX = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rn, id_rm, ex_rn, ex_rm, ex_destreg, mem_destreg, wb_destreg;
    logic             id_use_rn, id_use_rm, ex_memread, mem_regwrite, wb_regwrite;
    logic             br_taken, dmem_req, dmem_ready;
    logic             pc_en, ifde_en, idex_en, exmem_en;
    logic             ifde_flush, idex_flush, exmem_flush, memwb_bubble;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             mem_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rn_i        (id_rn),
        .id_rm_i        (id_rm),
        .id_use_rn_i    (id_use_rn),
        .id_use_rm_i    (id_use_rm),
        .ex_rn_i        (ex_rn),
        .ex_rm_i        (ex_rm),
        .ex_destreg_i   (ex_destreg),
        .ex_memread_i   (ex_memread),
        .mem_destreg_i  (mem_destreg),
        .mem_regwrite_i (mem_regwrite),
        .wb_destreg_i   (wb_destreg),
        .wb_regwrite_i  (wb_regwrite),
        .br_taken_i     (br_taken),
        .dmem_req_i     (dmem_req),
        .dmem_ready_i   (dmem_ready),
        .pc_en_o        (pc_en),
        .ifde_en_o      (ifde_en),
        .idex_en_o      (idex_en),
        .exmem_en_o     (exmem_en),
        .ifde_flush_o   (ifde_flush),
        .idex_flush_o   (idex_flush),
        .exmem_flush_o  (exmem_flush),
        .memwb_bubble_o (memwb_bubble),
        .fwd_a_o        (fwd_a),
        .fwd_b_o        (fwd_b),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt),
        .mem_timeout_o  (mem_timeout)
    );

    // en = {pc,ifde,idex,exmem}; fl = {ifde,idex,exmem,memwb}; use = {use_rn,use_rm}.
    // sc/fc/to are the registered values visible during the vector, i.e. before its own edge.
    typedef struct {
        logic       rst;
        logic [4:0] idrn, idrm;
        logic [1:0] use_;
        logic [4:0] exrn, exrm, exd;
        logic       ld;
        logic [4:0] md;
        logic       mrw;
        logic [4:0] wd;
        logic       wrw, br, req, rdy;
        logic [3:0] en, fl;
        logic [1:0] fa, fb;
        int         sc, fc;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic [4:0] idrn, idrm, input logic [1:0] use_,
        input logic [4:0] exrn, exrm, exd, input logic ld,
        input logic [4:0] md, input logic mrw, input logic [4:0] wd, input logic wrw,
        input logic br, req, rdy,
        input logic [3:0] en, fl, input logic [1:0] fa, fb, input int sc, fc, input logic to);
        vec_t v;
        v.rst = rst; v.idrn = idrn; v.idrm = idrm; v.use_ = use_;
        v.exrn = exrn; v.exrm = exrm; v.exd = exd; v.ld = ld;
        v.md = md; v.mrw = mrw; v.wd = wd; v.wrw = wrw;
        v.br = br; v.req = req; v.rdy = rdy;
        v.en = en; v.fl = fl; v.fa = fa; v.fb = fb; v.sc = sc; v.fc = fc; v.to = to;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst;
        id_rn = v.idrn; id_rm = v.idrm; {id_use_rn, id_use_rm} = v.use_;
        ex_rn = v.exrn; ex_rm = v.exrm; ex_destreg = v.exd; ex_memread = v.ld;
        mem_destreg = v.md; mem_regwrite = v.mrw; wb_destreg = v.wd; wb_regwrite = v.wrw;
        br_taken = v.br; dmem_req = v.req; dmem_ready = v.rdy;
    endtask

    vec_t idle;

    initial begin
        idle = mk(0, 0,0,2'b00, 0,0, 0,0, 0,0, 0,0, 0,0,0, 4'hF,4'h0,0,0, 0,0,0);
        //              rst idrn idrm use  exrn exrm exd ld md mrw wd wrw br req rdy  en       fl       fa     fb     sc fc to
        tbl.push_back(mk(1, 2, 4, 2'b11, 5, 0,  2, 1, 5, 1, 0, 0, 1, 0, 0, 4'b1111, 4'b0000, 2'b00, 2'b00, 0, 0, 0)); // 0 reset overrides
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 2'b00, 2'b00, 0, 0, 0)); // 1 idle
        tbl.push_back(mk(0, 2, 4, 2'b11, 0, 0,  2, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 4'b0100, 2'b00, 2'b00, 0, 0, 0)); // 2 T1 load-use
        tbl.push_back(mk(0, 2, 4, 2'b11, 0, 0,  2, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 2'b00, 2'b00, 1, 0, 0)); // 3 LU_STALL, no re-eval
        tbl.push_back(mk(0, 0, 0, 2'b00, 2, 4,  0, 0, 0, 0, 2, 1, 0, 0, 0, 4'b1111, 4'b0000, 2'b01, 2'b00, 1, 0, 0)); // 4 fwd from MEM/WB
        tbl.push_back(mk(0,31,31, 2'b11,31,31, 31, 1,31, 1,31, 1, 0, 0, 0, 4'b1111, 4'b0000, 2'b00, 2'b00, 1, 0, 0)); // 5 T2 XZR
        tbl.push_back(mk(0, 0, 0, 2'b00, 5, 7,  0, 0, 5, 1, 5, 1, 0, 0, 0, 4'b1111, 4'b0000, 2'b10, 2'b00, 1, 0, 0)); // 6 T3 double match
        tbl.push_back(mk(0, 0, 0, 2'b00, 5, 7,  0, 0, 5, 0, 5, 1, 0, 0, 0, 4'b1111, 4'b0000, 2'b01, 2'b00, 1, 0, 0)); // 7 drop mem_regwrite
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 9,  0, 0, 9, 1, 9, 1, 0, 0, 0, 4'b1111, 4'b0000, 2'b00, 2'b10, 1, 0, 0)); // 8 fwd_b
        tbl.push_back(mk(0, 6, 6, 2'b01, 0, 0,  6, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 4'b0100, 2'b00, 2'b00, 1, 0, 0)); // 9 load-use via rm
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 4'b1110, 2'b00, 2'b00, 2, 0, 0)); // 10 br in LU_STALL
        tbl.push_back(mk(0, 6, 0, 2'b10, 0, 0,  6, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 4'b0100, 2'b00, 2'b00, 2, 1, 0)); // 11 back in RUN
        tbl.push_back(idle); tbl[$].sc = 3; tbl[$].fc = 1;                                                          // 12
        tbl.push_back(mk(0, 6, 6, 2'b00, 0, 0,  6, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 2'b00, 2'b00, 3, 1, 0)); // 13 unused sources
        tbl.push_back(mk(0, 2, 4, 2'b11, 0, 0,  2, 1, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 4'b1110, 2'b00, 2'b00, 3, 1, 0)); // 14 T4 br + load-use
        tbl.push_back(mk(0, 2, 4, 2'b11, 0, 0,  2, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 4'b0100, 2'b00, 2'b00, 3, 2, 0)); // 15 state was RUN
        tbl.push_back(idle); tbl[$].sc = 4; tbl[$].fc = 2;                                                          // 16
        for (int i = 0; i < 3; i++)                                                                                 // 17-19 T5 freeze
            tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0001, 2'b00, 2'b00, 4 + i, 2, 0));
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b1111, 4'b0000, 2'b00, 2'b00, 7, 2, 0)); // 20 release
        tbl.push_back(idle); tbl[$].sc = 7; tbl[$].fc = 2;                                                          // 21
        tbl.push_back(mk(0, 2, 4, 2'b11, 0, 0,  2, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 4'b0100, 2'b00, 2'b00, 7, 2, 0)); // 22
        tbl.push_back(idle); tbl[$].sc = 7; tbl[$].fc = 2;                                                          // 23 stall_cnt saturated
        tbl.push_back(mk(0, 2, 4, 2'b11, 5, 0,  2, 1, 5, 1, 0, 0, 1, 1, 0, 4'b0000, 4'b0001, 2'b10, 2'b00, 7, 2, 0)); // 24 freeze wins
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b1111, 4'b0000, 2'b00, 2'b00, 7, 2, 0)); // 25
        for (int i = 0; i < 7; i++)                                                                                 // 26-32 flush_cnt saturates
            tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 4'b1110, 2'b00, 2'b00, 7, (i < 5) ? 2 + i : 7, 0));
        tbl.push_back(idle); tbl[$].sc = 7; tbl[$].fc = 7;                                                          // 33
        for (int i = 0; i < 6; i++)                                                                                 // 34-39 T6 timeout
            tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0001, 2'b00, 2'b00, 7, 7, (i >= 4) ? 1'b1 : 1'b0));
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b1111, 4'b0000, 2'b00, 2'b00, 7, 7, 1)); // 40 release, sticky
        tbl.push_back(idle); tbl[$].sc = 7; tbl[$].fc = 7; tbl[$].to = 1;                                           // 41
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0001, 2'b00, 2'b00, 7, 7, 1)); // 42
        tbl.push_back(mk(1, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 4'b0000, 2'b00, 2'b00, 7, 7, 1)); // 43 reset mid-wait
        tbl.push_back(idle);                                                                                        // 44 cleared
        tbl.push_back(mk(0, 2, 4, 2'b11, 0, 0,  2, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 4'b0100, 2'b00, 2'b00, 0, 0, 0)); // 45
        tbl.push_back(mk(1, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 4'b0000, 2'b00, 2'b00, 1, 0, 0)); // 46 reset mid-LU_STALL
        tbl.push_back(mk(0, 2, 4, 2'b11, 0, 0,  2, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 4'b0100, 2'b00, 2'b00, 0, 0, 0)); // 47 RUN again
        tbl.push_back(idle); tbl[$].sc = 1;                                                                         // 48

        drive(idle);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        foreach (tbl[r]) begin
            @(negedge clk);
            drive(tbl[r]);
            #2;
            chk("ctrl",   r, {20'd0, pc_en, ifde_en, idex_en, exmem_en, ifde_flush, idex_flush, exmem_flush,
                              memwb_bubble, fwd_a, fwd_b},
                             {20'd0, tbl[r].en, tbl[r].fl, tbl[r].fa, tbl[r].fb});
            chk("stall_cnt", r, 32'(stall_cnt), 32'(tbl[r].sc));
            chk("flush_cnt", r, 32'(flush_cnt), 32'(tbl[r].fc));
            chk("timeout",   r, 32'(mem_timeout), 32'(tbl[r].to));
        end

        // Hand-written wait: reset, three frozen cycles, release, then counter must read three.
        @(negedge clk);
        drive(idle);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dmem_req = 1'b1;
        dmem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("seq_frozen", 100 + c, {30'd0, pc_en, memwb_bubble}, 32'b01);
            @(negedge clk);
        end
        dmem_ready = 1'b1;
        #2;
        chk("seq_release", 103, {28'd0, pc_en, ifde_en, idex_en, memwb_bubble}, 32'b1110);
        @(negedge clk);
        dmem_req = 1'b0;
        #2;
        chk("seq_stall_cnt", 104, 32'(stall_cnt), 32'd3);
        chk("seq_timeout",   104, 32'(mem_timeout), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
